ifid_queue: RTL
===============

Name: ifid_queue

Overview:
Instruction queue between the fetch stage and decode; replaces the single IF/ID register.
- Buffers up to DEPTH fetched entries {PC, PC+4, instruction} so a decode stall does not stop fetch immediately.
- Drops all entries on a branch mispredict flush.
- Drives a NOP bubble into decode whenever it has nothing valid to present.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
XLEN, 32, width of PC and instruction fields
NOP_INSTR, 32'h00000013, instruction driven to decode when id_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
fetch_valid  input  1  fetch presents a valid entry this cycle
fetch_instr  input  XLEN  instruction from instruction memory
fetch_pc  input  XLEN  PC of fetch_instr
fetch_pc_plus4  input  XLEN  PC+4 of fetch_instr
fetch_ready  output  1  queue can accept; fetch uses it as PC_enable
flush  input  1  mispredict or redirect; discards all entries
id_ready  input  1  decode consumes the head entry this cycle
id_valid  output  1  head entry valid
id_instr  output  XLEN  head instruction, or NOP_INSTR when id_valid=0
id_pc  output  XLEN  head PC, or 0 when id_valid=0
id_pc_plus4  output  XLEN  head PC+4, or 0 when id_valid=0
ifq_count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (asynchronous, active-high):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, fetch_ready=1, ifq_count=0.
  - Storage contents are don't-care.
- Handshakes:
  - push = fetch_valid & fetch_ready.
  - pop = id_valid & id_ready.
- fetch_ready = (count != DEPTH). It depends only on registered count; there is no combinational path from id_ready.
- id_valid = (count != 0). Head fields are read combinationally from storage[rd_ptr].
- Latency: a push in cycle N appears at the head in cycle N+1 when the queue was empty, i.e. 1 cycle.
- Pointer update on posedge:
  - Push writes storage[wr_ptr] and increments wr_ptr mod DEPTH.
  - Pop increments rd_ptr mod DEPTH.
  - Count change: +1 on push only, -1 on pop only, unchanged on both.
- Full: fetch_ready=0 and no write occurs. A pop in the same cycle still frees the slot for the next cycle only; there is no push-through when full.
- Empty: id_valid=0 with NOP outputs, and id_ready is ignored.
- Flush has priority over everything:
  - Synchronously sets rd_ptr=wr_ptr=0 and count=0.
  - Any push or pop in the same cycle is discarded.
  - In the next cycle id_valid=0 and fetch_ready=1.
- Flush combined with fetch_valid: the redirected instruction is not captured that cycle. Fetch re-presents it the following cycle.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Invariant: count never exceeds DEPTH and never underflows; wrap-around of both pointers is mod DEPTH.

Optional Feature:
Macro IFQ_BYPASS_EN.
- Defined: when count==0, fetch_valid=1 and no flush, the fetch fields drive id_* combinationally and id_valid=1 (zero latency).
  - If id_ready=1 the entry is consumed and not written; pointers and count are unchanged.
  - If id_ready=0 the entry is written as a normal push.
  - fetch_ready rules are unchanged.
- Undefined: strict 1-cycle latency as described in Behaviour; no combinational path from fetch_* to id_*.

Decomposition:
- Package ifq_pkg holds:
  - NOP_INSTR constant.
  - Typedef ifq_entry_t, a packed struct {pc, pc_plus4, instr}, each XLEN.
  - Pointer and count width helper localparams.
- One sub-module, ifq_storage: a DEPTH x ifq_entry_t register array with one synchronous write port and one combinational read port.
- Pointer, count and flush logic stay in ifid_queue.

Test Plan:
1. Reset then idle → id_valid=0, id_instr=32'h00000013, fetch_ready=1, ifq_count=0.
2. Push PC=0x0, 0x4, 0x8, 0xC with id_ready=0 → fetch_ready=0 after the 4th push, ifq_count=4, head id_pc=0x0, id_pc_plus4=0x4. A 5th fetch_valid is not accepted.
3. From full, id_ready=1 for 4 cycles, no push → heads 0x0, 0x4, 0x8, 0xC in order, then id_valid=0. fetch_ready=1 one cycle after the first pop.
4. Simultaneous push/pop at count=2 for 10 cycles → count stays 2, order preserved across pointer wrap (≥2 wraps).
5. Count=3, assert flush together with fetch_valid (PC=0x40) and id_ready → next cycle count=0, id_valid=0, the 0x40 entry is absent. A push of 0x40 the next cycle appears at the head.
6. Assert rst asynchronously between clock edges at count=2 → outputs return to reset values before the next posedge. With IFQ_BYPASS_EN, an empty queue with fetch_valid=1, id_ready=1 gives id_valid=1 in the same cycle and ifq_count stays 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifq_pkg;

  // Native datapath width; the queue entry type is built from it.
  localparam int IFQ_XLEN  = 32;
  localparam int IFQ_DEPTH = 4;

  // addi x0,x0,0 -- presented to decode whenever the queue has nothing valid.
  localparam logic [IFQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction with its PC and the precomputed PC+4.
  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] pc_plus4;
    logic [IFQ_XLEN-1:0] instr;
  } ifq_entry_t;

  // Pointer width; at least one bit so a degenerate depth still elaborates.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width; must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the instruction queue: one synchronous write, one async read.
// Latency: write visible on the read port the cycle after wr_en.
// Backpressure: none; the owner guarantees writes only target free slots.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  ifq_entry_t       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output ifq_entry_t       rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  ifq_entry_t mem [DEPTH];

  // Capture the incoming entry into the addressed slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head entry is read combinationally so decode sees it the same cycle.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/ifid_queue.sv
// Fetch-to-decode instruction queue (DEPTH entries) with flush; optional zero-latency bypass via IFQ_BYPASS_EN.
// Latency: 1 cycle from push to head when empty; 0 cycles with IFQ_BYPASS_EN when empty.
// Backpressure: fetch_ready = (count != DEPTH) from registered state only; no push-through when full.
module ifid_queue
  import ifq_pkg::*;
#(
  parameter int                DEPTH     = IFQ_DEPTH,
  // Entry fields are IFQ_XLEN wide; XLEN must match that width.
  parameter int                XLEN      = IFQ_XLEN,
  parameter logic [XLEN-1:0]   NOP_INSTR = ifq_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_valid,
  input  logic [XLEN-1:0]             fetch_instr,
  input  logic [XLEN-1:0]             fetch_pc,
  input  logic [XLEN-1:0]             fetch_pc_plus4,
  output logic                        fetch_ready,
  input  logic                        flush,
  input  logic                        id_ready,
  output logic                        id_valid,
  output logic [XLEN-1:0]             id_instr,
  output logic [XLEN-1:0]             id_pc,
  output logic [XLEN-1:0]             id_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]  ifq_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       q_empty;
  logic       push;      // fetch handshake completes this cycle
  logic       wr_en;     // entry actually written into storage
  logic       pop;       // stored head entry consumed by decode
  logic       head_vld;  // something valid is presented to decode
  ifq_entry_t fetch_entry;
  ifq_entry_t head_entry;
  ifq_entry_t rd_entry;

  // Full/empty come from registered occupancy only.
  always_comb begin
    q_empty     = (count_q == '0);
    fetch_ready = (count_q != CNT_FULL);
  end

  // Pack the fetch fields into a queue entry.
  always_comb begin
    fetch_entry          = '0;
    fetch_entry.pc       = fetch_pc;
    fetch_entry.pc_plus4 = fetch_pc_plus4;
    fetch_entry.instr    = fetch_instr;
  end

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // When empty, a valid fetch is forwarded straight to decode; it is only
  // stored if decode does not take it this cycle.
  always_comb begin
    bypass     = q_empty & fetch_valid & ~flush;
    push       = fetch_valid & fetch_ready & ~flush;
    pop        = ~q_empty & id_ready & ~flush;
    wr_en      = push & ~(bypass & id_ready);
    head_vld   = ~q_empty | bypass;
    head_entry = bypass ? fetch_entry : rd_entry;
  end
`else
  // Strict registered path: decode only ever sees what is already stored.
  always_comb begin
    push       = fetch_valid & fetch_ready & ~flush;
    pop        = ~q_empty & id_ready & ~flush;
    wr_en      = push;
    head_vld   = ~q_empty;
    head_entry = rd_entry;
  end
`endif

  // Present the head entry, or a NOP bubble with zeroed PCs when idle.
  always_comb begin
    id_valid    = head_vld;
    id_instr    = NOP_INSTR;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (head_vld) begin
      id_instr    = head_entry.instr;
      id_pc       = head_entry.pc;
      id_pc_plus4 = head_entry.pc_plus4;
    end
    ifq_count = count_q;
  end

  // Next pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is mod DEPTH.
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (fetch_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

endmodule
